// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side signal bundle for the round-robin bus host arbiter.
// The arbiter connects through the slave modport; hosts and the downstream device use master.
interface bus_host_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic [NrHosts-1:0]                     host_req_i;
    logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i;
    logic [NrHosts-1:0]                     host_we_i;
    logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i;
    logic [NrHosts-1:0]                     host_gnt_o;
    logic [NrHosts-1:0]                     host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o;
    logic [NrHosts-1:0]                     host_err_o;

    logic                                   dev_req_o;
    logic [AddressWidth-1:0]                dev_addr_o;
    logic                                   dev_we_o;
    logic [DataWidth/8-1:0]                 dev_be_o;
    logic [DataWidth-1:0]                   dev_wdata_o;
    logic                                   dev_gnt_i;
    logic                                   dev_rvalid_i;
    logic [DataWidth-1:0]                   dev_rdata_i;
    logic                                   dev_err_i;

    logic                                   spurious_rvalid_o;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output spurious_rvalid_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  spurious_rvalid_o
    );
endinterface

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one downstream bus among NrHosts hosts, with an
// in-order ID FIFO that routes each device response back to the host that issued it.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// ST_FREE    | selection follows the round-robin pointer every cycle
// ST_LOCKED  | a request is on the bus but not yet granted; selection is frozen
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bus_host_arbiter_if.slave bus
);

    localparam int IdxW = $clog2(NrHosts);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   lock_sel_q, lock_sel_d;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   rr_sel, sel;
    logic [IdxW:0]     cand;

    logic [IdxW-1:0]   id_fifo_q [MaxOutstanding];
    logic [PtrW-1:0]   rd_q, wr_q;
    logic [CntW-1:0]   cnt_q;
    logic              fifo_full, fifo_empty;
    logic [IdxW-1:0]   head;

    logic              dev_req, grant, push, pop;
    logic [NrHosts-1:0]                 gnt_vec, rvalid_vec, err_vec;
    logic [NrHosts-1:0][DataWidth-1:0]  rdata_vec;

    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);
    assign head       = id_fifo_q[rd_q];

    // Scan from the highest offset down so the nearest requester at/after ptr wins.
    always_comb begin
        rr_sel = ptr_q;
        cand   = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NrHosts)) begin
                cand = cand - (IdxW + 1)'(NrHosts);
            end
            if (bus.host_req_i[cand[IdxW-1:0]]) begin
                rr_sel = cand[IdxW-1:0];
            end
        end
    end

    assign sel     = (state_q == ST_LOCKED) ? lock_sel_q : rr_sel;
    assign dev_req = bus.host_req_i[sel] & ~fifo_full & ~rst_i;
    assign grant   = dev_req & bus.dev_gnt_i;
    assign push    = grant;
    assign pop     = bus.dev_rvalid_i & ~fifo_empty & ~rst_i;

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            ST_FREE: begin
                if (dev_req && !bus.dev_gnt_i) begin
                    state_d    = ST_LOCKED;
                    lock_sel_d = rr_sel;
                end
            end
            ST_LOCKED: begin
                if (grant) begin
                    state_d = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_comb begin
        gnt_vec    = '0;
        rvalid_vec = '0;
        err_vec    = '0;
        rdata_vec  = '0;
        if (grant) begin
            gnt_vec[sel] = 1'b1;
        end
        if (pop) begin
            rvalid_vec[head] = 1'b1;
            err_vec[head]    = bus.dev_err_i;
            rdata_vec[head]  = bus.dev_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_FREE;
            lock_sel_q <= '0;
            ptr_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            if (grant) begin
                ptr_q <= (sel == IdxW'(NrHosts - 1)) ? '0 : sel + IdxW'(1);
            end
            if (push) begin
                wr_q <= (wr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_q + PtrW'(1);
            end
            if (pop) begin
                rd_q <= (rd_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ID storage needs no reset: only entries between rd_q and wr_q are ever read.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            id_fifo_q[wr_q] <= sel;
        end
    end

    assign bus.dev_req_o         = dev_req;
    assign bus.dev_addr_o        = bus.host_addr_i[sel];
    assign bus.dev_we_o          = bus.host_we_i[sel];
    assign bus.dev_be_o          = bus.host_be_i[sel];
    assign bus.dev_wdata_o       = bus.host_wdata_i[sel];
    assign bus.host_gnt_o        = gnt_vec;
    assign bus.host_rvalid_o     = rvalid_vec;
    assign bus.host_rdata_o      = rdata_vec;
    assign bus.host_err_o        = err_vec;
    assign bus.spurious_rvalid_o = bus.dev_rvalid_i & fifo_empty & ~rst_i;

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_bus_host_arbiter;

    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_host_arbiter_if #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW)) bus ();

    bus_host_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Host and device stimulus
    logic [N-1:0]  hreq = '0;
    logic [AW-1:0] haddr [N];
    logic          hwe   [N];
    logic [3:0]    hbe   [N];
    logic [DW-1:0] hwd   [N];
    logic          dgnt = 1'b0, drv = 1'b0, derr = 1'b0;
    logic [DW-1:0] drd  = '0;

    // Reference model: pointer, outstanding-ID queue, and the host currently waiting on the bus
    int m_ptr = 0;
    int m_q[$];
    int m_pend = -1;

    // Observations from the latest cycle, for directed checks
    logic [N-1:0]         obs_gnt, obs_rv, obs_err;
    logic [N-1:0][DW-1:0] obs_rd;
    logic                 obs_req, obs_sp;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic raise(input int h);
        if (!hreq[h]) begin
            hreq[h]  = 1'b1;
            haddr[h] = $urandom;
            hwe[h]   = 1'($urandom_range(0, 1));
            hbe[h]   = 4'($urandom_range(0, 15));
            hwd[h]   = $urandom;
        end
    endtask

    // Entered just after a falling edge; returns just after the next falling edge.
    task automatic cycle();
        int sel;
        int gnt_host;
        bit exp_req;
        logic [N-1:0]         e_gnt, e_rv, e_err;
        logic [N-1:0][DW-1:0] e_rd;
        logic                 e_sp;

        bus.host_req_i = hreq;
        for (int h = 0; h < N; h++) begin
            bus.host_addr_i[h]  = haddr[h];
            bus.host_we_i[h]    = hwe[h];
            bus.host_be_i[h]    = hbe[h];
            bus.host_wdata_i[h] = hwd[h];
        end
        bus.dev_gnt_i    = dgnt;
        bus.dev_rvalid_i = drv;
        bus.dev_rdata_i  = drd;
        bus.dev_err_i    = derr;
        #1;

        sel = -1;
        if (m_pend >= 0) sel = m_pend;
        else for (int k = 0; k < N; k++) if (sel < 0 && hreq[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        exp_req = (sel >= 0) && (m_q.size() < MAXO) && !rst;

        e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0; e_sp = 1'b0;
        if (exp_req && dgnt) e_gnt[sel] = 1'b1;
        if (drv && !rst) begin
            if (m_q.size() > 0) begin
                e_rv[m_q[0]]  = 1'b1;
                e_err[m_q[0]] = derr;
                e_rd[m_q[0]]  = drd;
            end else begin
                e_sp = 1'b1;
            end
        end

        obs_gnt = bus.host_gnt_o;   obs_rv  = bus.host_rvalid_o;
        obs_err = bus.host_err_o;   obs_rd  = bus.host_rdata_o;
        obs_req = bus.dev_req_o;    obs_sp  = bus.spurious_rvalid_o;

        check("dev_req", 128'(obs_req), 128'(exp_req));
        if (exp_req) begin
            check("dev_addr",  128'(bus.dev_addr_o),  128'(haddr[sel]));
            check("dev_we",    128'(bus.dev_we_o),    128'(hwe[sel]));
            check("dev_be",    128'(bus.dev_be_o),    128'(hbe[sel]));
            check("dev_wdata", 128'(bus.dev_wdata_o), 128'(hwd[sel]));
        end
        check("host_gnt",    128'(obs_gnt), 128'(e_gnt));
        check("host_rvalid", 128'(obs_rv),  128'(e_rv));
        check("host_err",    128'(obs_err), 128'(e_err));
        check("host_rdata",  128'(obs_rd),  128'(e_rd));
        check("spurious",    128'(obs_sp),  128'(e_sp));

        gnt_host = -1;
        if (rst) begin
            m_ptr = 0;
            m_q.delete();
            m_pend = -1;
        end else begin
            if (drv && m_q.size() > 0) void'(m_q.pop_front());
            if (exp_req && dgnt) begin
                m_q.push_back(sel);
                m_ptr    = (sel + 1) % N;
                m_pend   = -1;
                gnt_host = sel;
            end else if (exp_req) begin
                m_pend = sel;
            end
        end

        @(negedge clk);
        if (gnt_host >= 0) hreq[gnt_host] = 1'b0;
    endtask

    task automatic reset_cycle();
        rst = 1'b1; drv = 1'b0; dgnt = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int h = 0; h < N; h++) begin
            haddr[h] = '0; hwe[h] = 1'b0; hbe[h] = '0; hwd[h] = '0;
        end
        @(negedge clk);

        // Reset holds everything quiet even with requests and a response present
        raise(0); raise(2); drv = 1'b1; drd = $urandom; dgnt = 1'b1;
        cycle();
        check("rst_dev_req",  128'(obs_req), 128'(0));
        check("rst_spurious", 128'(obs_sp),  128'(0));
        hreq = '0;
        reset_cycle();

        // Two hosts streaming with a response one cycle after each grant: strict alternation
        dgnt = 1'b1; drv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            raise(0); raise(1);
            drd = $urandom; derr = 1'b0;
            cycle();
            check("alt_grant", 128'(obs_gnt), 128'((k % 2 == 0) ? 3'b001 : 3'b010));
            drv = (obs_gnt != '0);
        end
        hreq = '0; drv = 1'b1;
        cycle();
        drv = 1'b0;
        reset_cycle();

        // Response arriving with nothing outstanding
        drv = 1'b1; drd = 32'hDEADBEEF;
        cycle();
        check("empty_spurious", 128'(obs_sp), 128'(1));
        check("empty_rvalid",   128'(obs_rv), 128'(0));
        drv = 1'b0;

        // Selection stays on host 1 while ungranted even after host 0 asks
        raise(1); dgnt = 1'b0;
        cycle();
        raise(0);
        cycle();
        check("lock_addr", 128'(bus.dev_addr_o), 128'(haddr[1]));
        dgnt = 1'b1;
        cycle();
        check("lock_grant1", 128'(obs_gnt), 128'(3'b010));
        cycle();
        check("lock_grant0", 128'(obs_gnt), 128'(3'b001));
        dgnt = 1'b0; drv = 1'b1;
        cycle(); cycle();
        drv = 1'b0;

        // Error response routed to host 1 only
        reset_cycle();
        raise(1); dgnt = 1'b1;
        cycle();
        drv = 1'b1; derr = 1'b1; drd = $urandom;
        cycle();
        check("err_host1",   128'(obs_err),   128'(3'b010));
        check("rv_host1",    128'(obs_rv),    128'(3'b010));
        check("rdata_host0", 128'(obs_rd[0]), 128'(0));
        drv = 1'b0; derr = 1'b0;

        // FIFO full blocks the third request until a response pops one entry
        reset_cycle();
        dgnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            raise(0);
            cycle();
            check("full_gnt", 128'(obs_gnt), 128'((k < 2) ? 3'b001 : 3'b000));
        end
        drv = 1'b1;
        cycle();
        check("pop_no_gnt", 128'(obs_req), 128'(0));
        drv = 1'b0;
        cycle();
        check("resume_gnt", 128'(obs_gnt), 128'(3'b001));

        // Reset with two outstanding: late response is spurious, grant restarts at host 1
        raise(1); raise(2); dgnt = 1'b0;
        rst = 1'b1; drv = 1'b1;
        cycle();
        rst = 1'b0; dgnt = 1'b1;
        cycle();
        check("post_rst_spurious", 128'(obs_sp),  128'(1));
        check("post_rst_grant",    128'(obs_gnt), 128'(3'b010));
        drv = 1'b0;

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 80) == 0);
            for (int h = 0; h < N; h++) if ($urandom_range(0, 2) == 0) raise(h);
            dgnt = ($urandom_range(0, 3) != 0);
            drv  = ($urandom_range(0, 2) == 0);
            drd  = $urandom;
            derr = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
BUS_HOST_ARBITER -- requirements
Module: bus_host_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, data bus width.
REQ-003 SHALL have parameter AddressWidth, default 32, address bus width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, response-ID FIFO depth (1..4).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock; all state on rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 host_req_i  in  [NrHosts]x1  per-host request; held with its attributes until granted.
REQ-009 host_addr_i, host_we_i, host_be_i, host_wdata_i  in  [NrHosts]x AddressWidth/1/DataWidth/8 ... per-host attributes; host_be_i is DataWidth/8 bits.
REQ-010 host_gnt_o  out  [NrHosts]x1  per-host grant.
REQ-011 host_rvalid_o, host_rdata_o, host_err_o  out  [NrHosts]x 1/DataWidth/1  per-host response.
REQ-012 dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o  out  1/AW/1/DW/8/DW  shared downstream request.
REQ-013 dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i  in  1/1/DW/1  downstream grant and response.
REQ-014 spurious_rvalid_o  out  1  one-cycle pulse on a response with no outstanding transaction.

Function
REQ-015 SHALL select one host per cycle round-robin: first requesting host at or after priority pointer ptr, wrapping NrHosts-1 -> 0.
REQ-016 SHALL drive dev_req_o = 1 when any host requests and the ID FIFO is not full; dev_addr/we/be/wdata SHALL mux from the selected host.
REQ-017 Grant is combinational: host_gnt_o[sel] = dev_gnt_i & dev_req_o; all other host_gnt_o SHALL be 0.
REQ-018 On grant, ptr SHALL become (sel+1) mod NrHosts in the next cycle; without grant ptr SHALL hold.
REQ-019 Selection lock: once dev_req_o is high and not granted, sel SHALL not change until that grant, even if a higher-priority host raises req.
REQ-020 On grant, sel SHALL be pushed into the in-order ID FIFO (depth MaxOutstanding).
REQ-021 When the FIFO is full, dev_req_o SHALL be 0; a pop in the same cycle SHALL NOT enable a grant that cycle (grant resumes next cycle).
REQ-022 On dev_rvalid_i with non-empty FIFO: host_rvalid_o[head]=1, host_rdata_o[head]=dev_rdata_i, host_err_o[head]=dev_err_i, same cycle; head popped.
REQ-023 host_rdata_o/host_err_o of non-addressed hosts SHALL be 0; host_rvalid_o is 0 for them.
REQ-024 On dev_rvalid_i with empty FIFO: no host_rvalid_o, spurious_rvalid_o=1 for that cycle, no state change.
REQ-025 Simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged and preserve order.
REQ-026 Single host requesting SHALL see back-to-back grants every cycle while dev_gnt_i=1 and FIFO not full.

Reset
REQ-027 While rst_i=1: ptr=0, FIFO empty, lock cleared, spurious_rvalid_o=0, all host_rvalid_o=0; dev_req_o SHALL be 0.
REQ-028 Reset mid-transaction SHALL discard outstanding IDs; responses arriving after reset SHALL be flagged spurious.

Verification
REQ-029 Hosts 0,1 both request continuously, dev_gnt_i=1, rvalid 1 cycle after grant -> grants alternate 0,1,0,1; each host receives its own rdata in order.
REQ-030 MaxOutstanding=2, dev_rvalid_i held 0, host 0 requests 3 times -> 2 grants, then dev_req_o=0; first rvalid pop -> third grant one cycle later.
REQ-031 Host 1 requesting with dev_gnt_i=0, ptr=0, host 0 raises req -> dev_addr_o stays host 1's until granted; host 0 granted next.
REQ-032 dev_rvalid_i=1 with empty FIFO, dev_rdata_i=32'hDEADBEEF -> spurious_rvalid_o=1 one cycle, all host_rvalid_o=0.
REQ-033 Grant to host 1 with dev_err_i=1 on its response -> host_err_o[1]=1, host_rvalid_o[1]=1, host 0 outputs 0.
REQ-034 rst_i asserted with 2 outstanding, then one dev_rvalid_i -> spurious_rvalid_o=1, ptr=0, next grant goes to lowest requesting host.
